// File: rtl/fsm_01010_detector_pkg.sv
// ---------------------------------------------------------------------------
// fsm_01010_detector_pkg
//   Shared types and constants for the 0-1-0-1-0 serial sequence detector.
//   - state_t : 3-bit state encoding S0..S5 (codes 6 and 7 are unused)
//   - PATTERN : the detected bit sequence, first received bit in the MSB
// ---------------------------------------------------------------------------
package fsm_01010_detector_pkg;

  localparam int PATTERN_LEN = 5;

  // PATTERN[4] is the first bit on the wire, PATTERN[0] the last.
  localparam logic [PATTERN_LEN-1:0] PATTERN = 5'b01010;

  typedef enum logic [2:0] {
    S0 = 3'd0,
    S1 = 3'd1,
    S2 = 3'd2,
    S3 = 3'd3,
    S4 = 3'd4,
    S5 = 3'd5
  } state_t;

endpackage

// File: rtl/fsm_01010_detector_sat_counter.sv
// ---------------------------------------------------------------------------
// fsm_01010_detector_sat_counter
//   Saturating up-counter used for the debug match count. Holds at all-ones
//   instead of wrapping.
// Ports:
//   clk    in   1   rising-edge clock
//   rst    in   1   asynchronous reset, active-high, clears count
//   inc    in   1   increment request for this cycle
//   count  out  W   current count value
// ---------------------------------------------------------------------------
module fsm_01010_detector_sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic at_max;

  assign at_max = (count == {W{1'b1}});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fsm_01010_detector.sv
// ---------------------------------------------------------------------------
// fsm_01010_detector
//   Moore detector for the serial pattern 0-1-0-1-0 on x, one bit per rising
//   clk edge. y is high for the single cycle the FSM sits in S5. Overlapping
//   matches are optional; a saturating counter tracks detections for debug.
// Parameters:
//   OVERLAP      1: reuse suffix "0101" after a match; 0: restart after match
//   CNT_W        width of match_count
// Ports:
//   clk          in   1      rising-edge clock
//   rst          in   1      asynchronous reset, active-high
//   x            in   1      serial data bit
//   y            out  1      high while in S5 (01010 just received)
//   match_count  out  CNT_W  detections since reset, saturating
//
//   state | meaning
//   ------+-----------------------------
//   S0    | idle, no useful history
//   S1    | received "0"
//   S2    | received "01"
//   S3    | received "010"
//   S4    | received "0101"
//   S5    | received "01010", y = 1
// ---------------------------------------------------------------------------
module fsm_01010_detector
  import fsm_01010_detector_pkg::*;
#(
  parameter int OVERLAP = 1,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             x,
  output logic             y,
  output logic [CNT_W-1:0] match_count
);

  state_t state_q;
  state_t state_d;
  logic   enter_s5;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  // Each state advances when x equals the next expected pattern bit; on a
  // mismatch it falls back to the longest history that is still a prefix.
  always_comb begin
    state_d = S0;
    case (state_q)
      S0: state_d = (x == PATTERN[4]) ? S1 : S0;
      S1: state_d = (x == PATTERN[3]) ? S2 : S1;
      S2: state_d = (x == PATTERN[2]) ? S3 : S0;
      S3: state_d = (x == PATTERN[1]) ? S4 : S1;
      S4: state_d = (x == PATTERN[0]) ? S5 : S0;
      S5: begin
        if (x == PATTERN[4]) begin
          state_d = S1;
        end else begin
          // "01010" + '1' ends in "0101", reusable only when overlapping.
          state_d = (OVERLAP != 0) ? S4 : S0;
        end
      end
      default: state_d = S0;
    endcase
  end

  assign y        = (state_q == S5);
  assign enter_s5 = (state_d == S5) && (state_q != S5);

  fsm_01010_detector_sat_counter #(
    .W(CNT_W)
  ) u_match_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (enter_s5),
    .count(match_count)
  );

endmodule

// File: tb/tb_fsm_01010_detector.sv
module tb_fsm_01010_detector;

  logic       clk;
  logic       rst;
  logic       x;
  logic       y1;
  logic       y0;
  logic [7:0] c1;
  logic [7:0] c0;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       y1;
    logic       y0;
    logic [7:0] c1;
    logic [7:0] c0;
  } exp_t;

  exp_t sb[$];

  // reference model: bit history since reset (or since last match when not
  // overlapping); a match is the last five valid bits equal to 0,1,0,1,0
  logic [4:0] h1, h0;
  int         n1, n0;
  logic [7:0] m_c1, m_c0;

  fsm_01010_detector #(.OVERLAP(1), .CNT_W(8)) dut_ov (
    .clk(clk), .rst(rst), .x(x), .y(y1), .match_count(c1)
  );

  fsm_01010_detector #(.OVERLAP(0), .CNT_W(8)) dut_no (
    .clk(clk), .rst(rst), .x(x), .y(y0), .match_count(c0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_clear();
    h1 = '0; h0 = '0; n1 = 0; n0 = 0; m_c1 = '0; m_c0 = '0;
    sb.delete();
  endtask

  task automatic model_step(input logic b);
    exp_t e;
    logic m1, m0;
    h1 = {h1[3:0], b};
    h0 = {h0[3:0], b};
    if (n1 < 5) n1++;
    if (n0 < 5) n0++;
    m1 = (n1 == 5) && (h1 == 5'b01010);
    m0 = (n0 == 5) && (h0 == 5'b01010);
    if (m1 && m_c1 != 8'hFF) m_c1++;
    if (m0 && m_c0 != 8'hFF) m_c0++;
    if (m0) n0 = 0;
    e.y1 = m1; e.y0 = m0; e.c1 = m_c1; e.c0 = m_c0;
    sb.push_back(e);
  endtask

  // drive one bit away from the edge, record the expectation, step past the edge
  task automatic send(input logic b);
    @(negedge clk);
    x = b;
    model_step(b);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({y1, y0, c1, c0} !== 18'd0) begin
      failures++;
      $display("FAIL reset_initial got y1=%b y0=%b c1=%0d c0=%0d exp all 0", y1, y0, c1, c0);
    end
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({y1, y0, c1, c0} !== 18'd0) begin
        failures++;
        $display("FAIL reset_hold cyc%0d got y1=%b y0=%b c1=%0d c0=%0d exp all 0", i, y1, y0, c1, c0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_single();
    logic [4:0] seq;
    exp_t e;
    seq = 5'b01010;
    for (int i = 4; i >= 0; i--) begin
      send(seq[i]);
      e = sb.pop_front();
      checks++;
      if ({y1, c1} !== {e.y1, e.c1}) begin
        failures++;
        $display("FAIL single_ov bit%0d got y=%b cnt=%0d exp y=%b cnt=%0d", 4 - i, y1, c1, e.y1, e.c1);
      end
    end
    checks++;
    if (y1 !== 1'b1 || c1 !== 8'd1) begin
      failures++;
      $display("FAIL single_final got y=%b cnt=%0d exp y=1 cnt=1", y1, c1);
    end
    send(1'b0);
    e = sb.pop_front();
    checks++;
    if (y1 !== 1'b0 || e.y1 !== 1'b0) begin
      failures++;
      $display("FAIL single_drop got y=%b exp 0", y1);
    end
  endtask

  task automatic test_back_to_back();
    logic [6:0] seq;
    exp_t e;
    pulse_reset(1);
    seq = 7'b0101010;
    for (int i = 6; i >= 0; i--) begin
      send(seq[i]);
      e = sb.pop_front();
      checks++;
      if ({y1, c1} !== {e.y1, e.c1}) begin
        failures++;
        $display("FAIL b2b_ov bit%0d got y=%b cnt=%0d exp y=%b cnt=%0d", 6 - i, y1, c1, e.y1, e.c1);
      end
      checks++;
      if ({y0, c0} !== {e.y0, e.c0}) begin
        failures++;
        $display("FAIL b2b_no bit%0d got y=%b cnt=%0d exp y=%b cnt=%0d", 6 - i, y0, c0, e.y0, e.c0);
      end
    end
    checks++;
    if (c1 !== 8'd2 || c0 !== 8'd1) begin
      failures++;
      $display("FAIL b2b_counts got ov=%0d no=%0d exp ov=2 no=1", c1, c0);
    end
  endtask

  task automatic test_fallback_paths();
    logic [10:0] seq;
    exp_t e;
    pulse_reset(1);
    seq = 11'b01101001010;
    for (int i = 10; i >= 0; i--) begin
      send(seq[i]);
      e = sb.pop_front();
      checks++;
      if ({y1, y0, c1, c0} !== e) begin
        failures++;
        $display("FAIL fallback bit%0d got y1=%b y0=%b c1=%0d c0=%0d exp y1=%b y0=%b c1=%0d c0=%0d",
                 10 - i, y1, y0, c1, c0, e.y1, e.y0, e.c1, e.c0);
      end
    end
    checks++;
    if (y1 !== 1'b1 || c1 !== 8'd1 || c0 !== 8'd1) begin
      failures++;
      $display("FAIL fallback_final got y=%b ov=%0d no=%0d exp y=1 ov=1 no=1", y1, c1, c0);
    end
  endtask

  task automatic test_reset_mid_pattern();
    logic [3:0] seq;
    exp_t e;
    pulse_reset(1);
    seq = 4'b0101;
    for (int i = 3; i >= 0; i--) send(seq[i]);
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      checks++;
      if ({y1, y0, c1, c0} !== 18'd0) begin
        failures++;
        $display("FAIL midrst_hold got y1=%b y0=%b c1=%0d c0=%0d exp all 0", y1, y0, c1, c0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
    send(1'b0);
    e = sb.pop_front();
    checks++;
    if ({y1, y0, c1, c0} !== e || y1 !== 1'b0 || c1 !== 8'd0) begin
      failures++;
      $display("FAIL midrst_after got y1=%b y0=%b c1=%0d c0=%0d exp all 0", y1, y0, c1, c0);
    end
  endtask

  task automatic test_async_clear();
    logic [4:0] seq;
    pulse_reset(1);
    seq = 5'b01010;
    for (int i = 4; i >= 0; i--) send(seq[i]);
    sb.delete();
    checks++;
    if (y1 !== 1'b1) begin
      failures++;
      $display("FAIL async_pre got y=%b exp 1", y1);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({y1, y0, c1, c0} !== 18'd0) begin
      failures++;
      $display("FAIL async_clear got y1=%b y0=%b c1=%0d c0=%0d exp all 0", y1, y0, c1, c0);
    end
    @(negedge clk);
    rst = 1'b0;
    model_clear();
  endtask

  task automatic test_random();
    exp_t e;
    logic b;
    pulse_reset(1);
    for (int i = 0; i < 50; i++) begin
      b = 1'($urandom_range(0, 1));
      send(b);
      e = sb.pop_front();
      checks++;
      if ({y1, y0, c1, c0} !== e) begin
        failures++;
        $display("FAIL random bit%0d got y1=%b y0=%b c1=%0d c0=%0d exp y1=%b y0=%b c1=%0d c0=%0d",
                 i, y1, y0, c1, c0, e.y1, e.y0, e.c1, e.c0);
      end
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    logic [4:0] head;
    pulse_reset(1);
    head = 5'b01010;
    for (int i = 4; i >= 0; i--) send(head[i]);
    sb.delete();
    for (int i = 0; i < 270; i++) begin
      for (int k = 0; k < 2; k++) begin
        send(k == 0 ? 1'b1 : 1'b0);
        e = sb.pop_front();
        checks++;
        if ({y1, y0, c1, c0} !== e) begin
          failures++;
          $display("FAIL saturate iter%0d.%0d got y1=%b y0=%b c1=%0d c0=%0d exp y1=%b y0=%b c1=%0d c0=%0d",
                   i, k, y1, y0, c1, c0, e.y1, e.y0, e.c1, e.c0);
        end
      end
    end
    checks++;
    if (c1 !== 8'hFF || y1 !== 1'b1) begin
      failures++;
      $display("FAIL saturate_final got cnt=%0d y=%b exp cnt=255 y=1", c1, y1);
    end
  endtask

  initial begin
    rst = 1'b1;
    x   = 1'b0;
    model_clear();
    test_reset();
    test_single();
    test_back_to_back();
    test_fallback_paths();
    test_reset_mid_pattern();
    test_async_clear();
    test_random();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
